// File: rtl/flush_redirect_ctrl.sv
// Flush/redirect sequencer between writeback, CSR file and fetch.
// Define FLUSH_CTRL_IDLE_EN to build the IDLE_WAIT state and the idle cycle counter.
module flush_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic        refetch_flush,
  input  logic        icacop_flush,
  input  logic        idle_flush,
  input  logic [31:0] ws_pc,
  input  logic        excp_tlbrefill,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_tlbrentry,
  input  logic [31:0] csr_era,
  input  logic        has_int,
  input  logic        icache_cacop_done,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        fetch_hold,
  output logic [2:0]  flush_cause,
  output logic [31:0] idle_cycles
);

  typedef enum logic [1:0] {
    S_RUN,
    S_CACOP_WAIT
`ifdef FLUSH_CTRL_IDLE_EN
    ,
    S_IDLE_WAIT
`endif
  } state_e;

  state_e      state_q, state_d;
  logic        pipe_flush_q, pipe_flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        fetch_hold_q, fetch_hold_d;
  logic [2:0]  flush_cause_q, flush_cause_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] seq_pc;

  assign seq_pc = ws_pc + 32'd4;

  always_comb begin
    state_d          = state_q;
    pipe_flush_d     = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_cause_d    = 3'd0;
    pend_pc_d        = pend_pc_q;
    unique case (state_q)
      S_RUN: begin
        if (excp_flush) begin
          pipe_flush_d     = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = excp_tlbrefill ? csr_tlbrentry : csr_eentry;
          flush_cause_d    = 3'd1;
        end else if (ertn_flush) begin
          pipe_flush_d     = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = csr_era;
          flush_cause_d    = 3'd2;
        end else if (icacop_flush) begin
          pipe_flush_d  = 1'b1;
          flush_cause_d = 3'd3;
          pend_pc_d     = seq_pc;
          state_d       = S_CACOP_WAIT;
        end else if (idle_flush) begin
          pipe_flush_d  = 1'b1;
          flush_cause_d = 3'd4;
`ifdef FLUSH_CTRL_IDLE_EN
          pend_pc_d     = seq_pc;
          state_d       = S_IDLE_WAIT;
`else
          redirect_valid_d = 1'b1;
          redirect_pc_d    = seq_pc;
`endif
        end else if (refetch_flush) begin
          pipe_flush_d     = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = seq_pc;
          flush_cause_d    = 3'd5;
        end
      end
      S_CACOP_WAIT: begin
        if (icache_cacop_done) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = pend_pc_q;
          state_d          = S_RUN;
        end
      end
`ifdef FLUSH_CTRL_IDLE_EN
      S_IDLE_WAIT: begin
        if (has_int) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = pend_pc_q;
          state_d          = S_RUN;
        end
      end
`endif
      default: state_d = S_RUN;
    endcase
    // Registered from next state so hold covers the wake-sampling cycle and drops with the redirect.
    fetch_hold_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_RUN;
      pipe_flush_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= RESET_PC;
      fetch_hold_q     <= 1'b0;
      flush_cause_q    <= 3'd0;
      pend_pc_q        <= '0;
    end else begin
      state_q          <= state_d;
      pipe_flush_q     <= pipe_flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      fetch_hold_q     <= fetch_hold_d;
      flush_cause_q    <= flush_cause_d;
      pend_pc_q        <= pend_pc_d;
    end
  end

`ifdef FLUSH_CTRL_IDLE_EN
  logic [31:0] idle_cycles_q, idle_cycles_d;

  always_comb begin
    idle_cycles_d = idle_cycles_q;
    if (state_q == S_IDLE_WAIT && idle_cycles_q != '1)
      idle_cycles_d = idle_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) idle_cycles_q <= '0;
    else       idle_cycles_q <= idle_cycles_d;
  end

  assign idle_cycles = idle_cycles_q;
`else
  logic unused_has_int;
  assign unused_has_int = has_int;
  assign idle_cycles    = '0;
`endif

  assign pipe_flush     = pipe_flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign fetch_hold     = fetch_hold_q;
  assign flush_cause    = flush_cause_q;

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Self-checking bench for flush_redirect_ctrl: directed scenarios plus randomized
// traffic against a request-kind reference model. Follows FLUSH_CTRL_IDLE_EN.
module tb_flush_redirect_ctrl;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        excp_flush, ertn_flush, refetch_flush, icacop_flush, idle_flush;
  logic [31:0] ws_pc;
  logic        excp_tlbrefill;
  logic [31:0] csr_eentry, csr_tlbrentry, csr_era;
  logic        has_int, icache_cacop_done;
  logic        pipe_flush, redirect_valid, fetch_hold;
  logic [31:0] redirect_pc, idle_cycles;
  logic [2:0]  flush_cause;

  int checks = 0;
  int errors = 0;

  // Reference model: which wait (0 none, 1 cacop, 2 idle) and expected outputs.
  int          m_wait;
  logic [31:0] m_pend;
  logic        m_pf, m_rv, m_hold;
  logic [31:0] m_pc, m_idle;
  logic [2:0]  m_cause;

`ifdef FLUSH_CTRL_IDLE_EN
  localparam bit IDLE_EN = 1'b1;
`else
  localparam bit IDLE_EN = 1'b0;
`endif

  flush_redirect_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .refetch_flush(refetch_flush),
    .icacop_flush(icacop_flush), .idle_flush(idle_flush), .ws_pc(ws_pc),
    .excp_tlbrefill(excp_tlbrefill), .csr_eentry(csr_eentry), .csr_tlbrentry(csr_tlbrentry),
    .csr_era(csr_era), .has_int(has_int), .icache_cacop_done(icache_cacop_done),
    .pipe_flush(pipe_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_hold(fetch_hold), .flush_cause(flush_cause), .idle_cycles(idle_cycles)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    reset = 1'b0; excp_flush = 1'b0; ertn_flush = 1'b0; refetch_flush = 1'b0;
    icacop_flush = 1'b0; idle_flush = 1'b0; ws_pc = '0; excp_tlbrefill = 1'b0;
    csr_eentry = 32'h1c008000; csr_tlbrentry = 32'h1c00f000; csr_era = 32'h1c000010;
    has_int = 1'b0; icache_cacop_done = 1'b0;
  endtask

  // Advance the model from the current inputs, then cross one clock edge.
  task automatic tick();
    int kind;
    logic [31:0] tgt;
    if (reset) begin
      m_wait = 0; m_pend = '0; m_pf = 0; m_rv = 0; m_pc = RST_PC;
      m_cause = 0; m_hold = 0; m_idle = '0;
    end else begin
      m_pf = 0; m_rv = 0; m_cause = 0;
      if (m_wait == 2 && m_idle != 32'hffffffff) m_idle = m_idle + 1;
      if (m_wait == 0) begin
        kind = excp_flush ? 1 : ertn_flush ? 2 : icacop_flush ? 3 :
               idle_flush ? 4 : refetch_flush ? 5 : 0;
        case (kind)
          1: tgt = excp_tlbrefill ? csr_tlbrentry : csr_eentry;
          2: tgt = csr_era;
          default: tgt = ws_pc + 32'd4;
        endcase
        if (kind != 0) begin
          m_pf = 1; m_cause = 3'(kind);
          if (kind == 3) begin m_wait = 1; m_pend = tgt; end
          else if (kind == 4 && IDLE_EN) begin m_wait = 2; m_pend = tgt; end
          else begin m_rv = 1; m_pc = tgt; end
        end
      end else if ((m_wait == 1 && icache_cacop_done) || (m_wait == 2 && has_int)) begin
        m_wait = 0; m_rv = 1; m_pc = m_pend;
      end
      m_hold = (m_wait != 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({pipe_flush, redirect_valid, fetch_hold, flush_cause} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got pf=%b rv=%b hold=%b cause=%0d want all 0",
               pipe_flush, redirect_valid, fetch_hold, flush_cause);
    end
    checks++;
    if (redirect_pc !== RST_PC || idle_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_pc got pc=%h idle=%0d want pc=%h idle=0", redirect_pc, idle_cycles, RST_PC);
    end
    reset = 1'b0;
  endtask

  task automatic test_excp();
    clear_inputs();
    excp_flush = 1'b1; excp_tlbrefill = 1'b1; csr_tlbrentry = 32'h1c001000;
    tick();
    clear_inputs();
    checks++;
    if (pipe_flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h1c001000 || flush_cause !== 3'd1) begin
      errors++;
      $display("FAIL excp got pf=%b rv=%b pc=%h cause=%0d want 1 1 1c001000 1",
               pipe_flush, redirect_valid, redirect_pc, flush_cause);
    end
    tick();
    checks++;
    if (pipe_flush !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h1c001000) begin
      errors++;
      $display("FAIL excp_pulse_end got pf=%b rv=%b pc=%h want 0 0 1c001000",
               pipe_flush, redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    ertn_flush = 1'b1; refetch_flush = 1'b1; csr_era = 32'h1c000040; ws_pc = 32'h1c000500;
    tick();
    clear_inputs();
    checks++;
    if (pipe_flush !== 1'b1 || redirect_pc !== 32'h1c000040 || flush_cause !== 3'd2) begin
      errors++;
      $display("FAIL priority got pf=%b pc=%h cause=%0d want 1 1c000040 2", pipe_flush, redirect_pc, flush_cause);
    end
    tick();
    checks++;
    if (pipe_flush !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL priority_single got pf=%b rv=%b want 0 0", pipe_flush, redirect_valid);
    end
  endtask

  task automatic test_icacop();
    int hold_cnt = 0;
    clear_inputs();
    icacop_flush = 1'b1; ws_pc = 32'h1c000100;
    has_int = 1'b1; icache_cacop_done = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (pipe_flush !== 1'b1 || redirect_valid !== 1'b0 || flush_cause !== 3'd3 || fetch_hold !== 1'b1) begin
      errors++;
      $display("FAIL icacop_entry got pf=%b rv=%b cause=%0d hold=%b want 1 0 3 1",
               pipe_flush, redirect_valid, flush_cause, fetch_hold);
    end
    if (fetch_hold === 1'b1) hold_cnt++;
    excp_flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (fetch_hold === 1'b1 && redirect_valid === 1'b0 && pipe_flush === 1'b0) hold_cnt++;
    end
    excp_flush = 1'b0;
    icache_cacop_done = 1'b1;
    tick();
    icache_cacop_done = 1'b0;
    checks++;
    if (hold_cnt != 5) begin
      errors++;
      $display("FAIL icacop_hold_len got %0d cycles want 5", hold_cnt);
    end
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c000104 || fetch_hold !== 1'b0 || pipe_flush !== 1'b0) begin
      errors++;
      $display("FAIL icacop_wake got rv=%b pc=%h hold=%b pf=%b want 1 1c000104 0 0",
               redirect_valid, redirect_pc, fetch_hold, pipe_flush);
    end
  endtask

`ifdef FLUSH_CTRL_IDLE_EN
  task automatic test_idle();
    clear_inputs();
    reset = 1'b1; tick(); reset = 1'b0;
    idle_flush = 1'b1; ws_pc = 32'hfffffffc;
    tick();
    clear_inputs();
    checks++;
    if (pipe_flush !== 1'b1 || flush_cause !== 3'd4 || redirect_valid !== 1'b0 || fetch_hold !== 1'b1) begin
      errors++;
      $display("FAIL idle_entry got pf=%b cause=%0d rv=%b hold=%b want 1 4 0 1",
               pipe_flush, flush_cause, redirect_valid, fetch_hold);
    end
    for (int i = 0; i < 9; i++) tick();
    has_int = 1'b1;
    tick();
    has_int = 1'b0;
    checks++;
    if (idle_cycles !== 32'd10 || redirect_valid !== 1'b1 || redirect_pc !== 32'h0 || fetch_hold !== 1'b0) begin
      errors++;
      $display("FAIL idle_wake got idle=%0d rv=%b pc=%h hold=%b want 10 1 00000000 0",
               idle_cycles, redirect_valid, redirect_pc, fetch_hold);
    end
  endtask
`else
  task automatic test_idle_off();
    clear_inputs();
    idle_flush = 1'b1; ws_pc = 32'h1c000200;
    tick();
    clear_inputs();
    checks++;
    if (pipe_flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h1c000204 ||
        flush_cause !== 3'd4 || fetch_hold !== 1'b0 || idle_cycles !== 32'd0) begin
      errors++;
      $display("FAIL idle_off got pf=%b rv=%b pc=%h cause=%0d hold=%b idle=%0d want 1 1 1c000204 4 0 0",
               pipe_flush, redirect_valid, redirect_pc, flush_cause, fetch_hold, idle_cycles);
    end
  endtask
`endif

  task automatic test_reset_mid_wait();
    clear_inputs();
    if (IDLE_EN) idle_flush = 1'b1; else icacop_flush = 1'b1;
    ws_pc = 32'h1c000300;
    tick();
    clear_inputs();
    tick(); tick();
    reset = 1'b1; has_int = 1'b1; icache_cacop_done = 1'b1;
    tick();
    checks++;
    if (redirect_valid !== 1'b0 || fetch_hold !== 1'b0 || idle_cycles !== 32'd0 || redirect_pc !== RST_PC) begin
      errors++;
      $display("FAIL reset_mid_wait got rv=%b hold=%b idle=%0d pc=%h want 0 0 0 %h",
               redirect_valid, fetch_hold, idle_cycles, redirect_pc, RST_PC);
    end
    clear_inputs();
    tick();
    checks++;
    if (redirect_valid !== 1'b0 || fetch_hold !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_redirect got rv=%b hold=%b want 0 0", redirect_valid, fetch_hold);
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    refetch_flush = 1'b1; ws_pc = 32'h1c000400;
    tick();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c000404 || flush_cause !== 3'd5) begin
      errors++;
      $display("FAIL b2b_first got rv=%b pc=%h cause=%0d want 1 1c000404 5", redirect_valid, redirect_pc, flush_cause);
    end
    refetch_flush = 1'b0; ertn_flush = 1'b1; csr_era = 32'h1c000800;
    tick();
    clear_inputs();
    checks++;
    if (pipe_flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h1c000800 || flush_cause !== 3'd2) begin
      errors++;
      $display("FAIL b2b_second got pf=%b rv=%b pc=%h cause=%0d want 1 1 1c000800 2",
               pipe_flush, redirect_valid, redirect_pc, flush_cause);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 99) == 0);
      excp_flush     = ($urandom_range(0, 9) == 0);
      ertn_flush     = ($urandom_range(0, 9) == 0);
      refetch_flush  = ($urandom_range(0, 7) == 0);
      icacop_flush   = ($urandom_range(0, 9) == 0);
      idle_flush     = ($urandom_range(0, 9) == 0);
      ws_pc          = ($urandom_range(0, 15) == 0) ? 32'hfffffffc : $urandom;
      excp_tlbrefill = $urandom_range(0, 1) == 1;
      csr_eentry     = $urandom;
      csr_tlbrentry  = $urandom;
      csr_era        = $urandom;
      has_int        = ($urandom_range(0, 4) == 0);
      icache_cacop_done = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (pipe_flush !== m_pf || redirect_valid !== m_rv || redirect_pc !== m_pc ||
          flush_cause !== m_cause || fetch_hold !== m_hold || idle_cycles !== m_idle) begin
        errors++;
        $display("FAIL random[%0d] got pf=%b rv=%b pc=%h cause=%0d hold=%b idle=%0d want %b %b %h %0d %b %0d",
                 n, pipe_flush, redirect_valid, redirect_pc, flush_cause, fetch_hold, idle_cycles,
                 m_pf, m_rv, m_pc, m_cause, m_hold, m_idle);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_excp();
    test_priority();
    test_icacop();
`ifdef FLUSH_CTRL_IDLE_EN
    test_idle();
`else
    test_idle_off();
`endif
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
